// File: rtl/gf4_sqscmul_arbiter_if.sv
// Request/response and datapath bundle between two requesters, the arbiter and
// the shared pipelined GF(4) square-scale-multiply unit.
interface gf4_sqscmul_arbiter_if #(
  parameter int unsigned SHARES = 2,
  parameter int unsigned TAG_W  = 4
);
  localparam int unsigned D_W = 4 * SHARES;
  localparam int unsigned Z_W = 2 * SHARES * (SHARES - 1);

  logic             ReqValidAxSI;
  logic             ReqReadyAxSO;
  logic [D_W-1:0]   ReqXAxDI;
  logic [D_W-1:0]   ReqYAxDI;
  logic [TAG_W-1:0] ReqTagAxDI;

  logic             ReqValidBxSI;
  logic             ReqReadyBxSO;
  logic [D_W-1:0]   ReqXBxDI;
  logic [D_W-1:0]   ReqYBxDI;
  logic [TAG_W-1:0] ReqTagBxDI;

  logic [D_W-1:0]   _XxDO;
  logic [D_W-1:0]   _YxDO;
  logic [Z_W-1:0]   _ZxDO;
  logic [D_W-1:0]   _QxDI;

  logic             RespValidAxSO;
  logic             RespValidBxSO;
  logic [D_W-1:0]   RespQxDO;
  logic [TAG_W-1:0] RespTagxDO;
  logic             BusyxSO;

  // Arbiter side
  modport slave (
    input  ReqValidAxSI, ReqXAxDI, ReqYAxDI, ReqTagAxDI,
    input  ReqValidBxSI, ReqXBxDI, ReqYBxDI, ReqTagBxDI,
    input  _QxDI,
    output ReqReadyAxSO, ReqReadyBxSO,
    output _XxDO, _YxDO, _ZxDO,
    output RespValidAxSO, RespValidBxSO, RespQxDO, RespTagxDO, BusyxSO
  );

  // Requester/datapath side
  modport master (
    output ReqValidAxSI, ReqXAxDI, ReqYAxDI, ReqTagAxDI,
    output ReqValidBxSI, ReqXBxDI, ReqYBxDI, ReqTagBxDI,
    output _QxDI,
    input  ReqReadyAxSO, ReqReadyBxSO,
    input  _XxDO, _YxDO, _ZxDO,
    input  RespValidAxSO, RespValidBxSO, RespQxDO, RespTagxDO, BusyxSO
  );
endinterface

// File: rtl/gf4_sqscmul_arbiter.sv
// Round-robin sharing of one pipelined masked GF(4) square-scale-multiply unit
// between requesters A and B, with LFSR randomness and in-order result routing.
module gf4_sqscmul_arbiter #(
  parameter int unsigned SHARES    = 2,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned TAG_W     = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  gf4_sqscmul_arbiter_if.slave  bus
);
  localparam int unsigned D_W       = 4 * SHARES;
  localparam int unsigned Z_W       = 2 * SHARES * (SHARES - 1);
  localparam int unsigned LAST      = LATENCY - 1;
  localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;
  localparam logic        ID_A      = 1'b0;
  localparam logic        ID_B      = 1'b1;

  typedef struct packed {
    logic             valid;
    logic             id;
    logic [TAG_W-1:0] tag;
  } trk_t;

  logic             grant_a_c, grant_b_c, busy_c;
  logic             ptr_q, ptr_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [Z_W-1:0]   z_q, z_d;
  logic [D_W-1:0]   x_q, x_d, y_q, y_d;
  trk_t             issue_q, issue_d;
  trk_t             trk_q [LATENCY];
  trk_t             trk_d [LATENCY];
  logic             resp_a_q, resp_a_d, resp_b_q, resp_b_d;
  logic [D_W-1:0]   resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  // Grant selection; pointer (0 = A) only moves on contended grants
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    ptr_d     = ptr_q;
    if (!RstxBI) begin
      if (bus.ReqValidAxSI && bus.ReqValidBxSI) begin
        grant_a_c = (ptr_q == ID_A);
        grant_b_c = (ptr_q == ID_B);
        ptr_d     = ~ptr_q;
      end else begin
        grant_a_c = bus.ReqValidAxSI;
        grant_b_c = bus.ReqValidBxSI;
      end
    end
  end

  // Issue registers: idle cycles load zeros so old shares are never re-sent
  always_comb begin
    x_d     = '0;
    y_d     = '0;
    issue_d = '0;
    if (grant_a_c) begin
      x_d           = bus.ReqXAxDI;
      y_d           = bus.ReqYAxDI;
      issue_d.valid = 1'b1;
      issue_d.id    = ID_A;
      issue_d.tag   = bus.ReqTagAxDI;
    end else if (grant_b_c) begin
      x_d           = bus.ReqXBxDI;
      y_d           = bus.ReqYBxDI;
      issue_d.valid = 1'b1;
      issue_d.id    = ID_B;
      issue_d.tag   = bus.ReqTagBxDI;
    end
  end

  // Galois LFSR x^32+x^22+x^2+x+1; nonzero seed keeps it off the zero state
  always_comb begin
    lfsr_d = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? LFSR_TAPS : 32'h0);
    z_d    = lfsr_q[Z_W-1:0];
  end

  // Tracking line runs beside the datapath; its tail tags the returning result
  always_comb begin
    trk_d[0] = issue_q;
    for (int i = 1; i < int'(LATENCY); i++) begin
      trk_d[i] = trk_q[i-1];
    end
    resp_a_d    = 1'b0;
    resp_b_d    = 1'b0;
    resp_data_d = '0;
    resp_tag_d  = '0;
    if (trk_q[LAST].valid) begin
      resp_a_d    = (trk_q[LAST].id == ID_A);
      resp_b_d    = (trk_q[LAST].id == ID_B);
      resp_data_d = bus._QxDI;
      resp_tag_d  = trk_q[LAST].tag;
    end
  end

  always_comb begin
    busy_c = issue_q.valid | resp_a_q | resp_b_q;
    for (int i = 0; i < int'(LATENCY); i++) begin
      busy_c = busy_c | trk_q[i].valid;
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxBI) begin
      ptr_q       <= ID_A;
      lfsr_q      <= LFSR_SEED;
      z_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      issue_q     <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        trk_q[i] <= '0;
      end
      resp_a_q    <= 1'b0;
      resp_b_q    <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lfsr_q      <= lfsr_d;
      z_q         <= z_d;
      x_q         <= x_d;
      y_q         <= y_d;
      issue_q     <= issue_d;
      for (int i = 0; i < int'(LATENCY); i++) begin
        trk_q[i] <= trk_d[i];
      end
      resp_a_q    <= resp_a_d;
      resp_b_q    <= resp_b_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

  assign bus.ReqReadyAxSO  = grant_a_c;
  assign bus.ReqReadyBxSO  = grant_b_c;
  assign bus._XxDO         = x_q;
  assign bus._YxDO         = y_q;
  assign bus._ZxDO         = z_q;
  assign bus.RespValidAxSO = resp_a_q;
  assign bus.RespValidBxSO = resp_b_q;
  assign bus.RespQxDO      = resp_data_q;
  assign bus.RespTagxDO    = resp_tag_q;
  assign bus.BusyxSO       = busy_c;
endmodule

// File: tb/tb_gf4_sqscmul_arbiter.sv
// Directed bench: arbitration order, response routing/latency, randomness and
// mid-flight reset, with a behavioural one-stage masked datapath attached.
module tb_gf4_sqscmul_arbiter;
  localparam int unsigned SHARES = 2;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned D_W    = 8;
  localparam int unsigned Z_W    = 4;
  localparam logic [31:0] SEED   = 32'hACE12468;
  localparam logic [31:0] TAPS   = 32'h0040_0007;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf4_sqscmul_arbiter_if #(.SHARES(SHARES), .TAG_W(TAG_W)) bus ();

  gf4_sqscmul_arbiter #(
    .SHARES(SHARES), .LATENCY(1), .TAG_W(TAG_W), .LFSR_SEED(SEED)
  ) dut (
    .ClkxCI(clk),
    .RstxBI(rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // GF(16) arithmetic, polynomial basis mod x^4+x+1
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // Reference square-scale-multiply: nu*(x^y)^2 + x*y with nu = x (4'h2)
  function automatic logic [3:0] gf_ref(input logic [3:0] x, input logic [3:0] y);
    return gf16_mul(4'h2, gf16_mul(x ^ y, x ^ y)) ^ gf16_mul(x, y);
  endfunction

  function automatic logic [3:0] unmask(input logic [7:0] s);
    return s[3:0] ^ s[7:4];
  endfunction

  function automatic logic [7:0] mask4(input logic [3:0] v);
    logic [3:0] r;
    r = 4'($urandom);
    return {r, v ^ r};
  endfunction

  // One-stage masked datapath model, remasked with the supplied randomness
  logic [D_W-1:0] q_m = '0;
  always @(posedge clk)
    q_m <= {bus._ZxDO, gf_ref(unmask(bus._XxDO), unmask(bus._YxDO)) ^ bus._ZxDO};
  assign bus._QxDI = q_m;

  // Randomness reference
  logic [31:0]    lfsr_m;
  logic [Z_W-1:0] z_m;
  always @(posedge clk) begin
    if (rst) begin
      lfsr_m <= SEED;
      z_m    <= '0;
    end else begin
      z_m    <= lfsr_m[Z_W-1:0];
      lfsr_m <= {lfsr_m[30:0], 1'b0} ^ (lfsr_m[31] ? TAPS : 32'h0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       id;
    logic [3:0] tag;
    logic [3:0] gold;
  } exp_t;
  exp_t sb[$];

  int             z_changes = 0;
  logic [Z_W-1:0] z_prev    = '0;

  // Response scoreboard: a grant seen in cycle c must answer in cycle c+3
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      check_eq("z_rand", 32'(bus._ZxDO), 32'(z_m));
      if (bus._ZxDO !== z_prev) z_changes++;
      z_prev = bus._ZxDO;
      check_eq("grant_legal",
               {29'h0, bus.ReqReadyAxSO & bus.ReqReadyBxSO,
                bus.ReqReadyAxSO & ~bus.ReqValidAxSI,
                bus.ReqReadyBxSO & ~bus.ReqValidBxSI}, 32'h0);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check_eq("resp_valid_a", 32'(bus.RespValidAxSO), 32'(e.id == 1'b0));
        check_eq("resp_valid_b", 32'(bus.RespValidBxSO), 32'(e.id == 1'b1));
        check_eq("resp_tag", 32'(bus.RespTagxDO), 32'(e.tag));
        check_eq("resp_q", 32'(unmask(bus.RespQxDO)), 32'(e.gold));
      end else begin
        check_eq("resp_idle", 32'({bus.RespValidAxSO, bus.RespValidBxSO,
                                    bus.RespQxDO, bus.RespTagxDO}), 32'h0);
      end
      if (bus.ReqReadyAxSO) begin
        e.due = cyc + 3; e.id = 1'b0; e.tag = bus.ReqTagAxDI;
        e.gold = gf_ref(unmask(bus.ReqXAxDI), unmask(bus.ReqYAxDI));
        sb.push_back(e);
      end
      if (bus.ReqReadyBxSO) begin
        e.due = cyc + 3; e.id = 1'b1; e.tag = bus.ReqTagBxDI;
        e.gold = gf_ref(unmask(bus.ReqXBxDI), unmask(bus.ReqYBxDI));
        sb.push_back(e);
      end
    end
  end

  // Apply one cycle of stimulus just after the edge, return at the falling edge
  task automatic drive(input logic r,
                       input logic va, input logic [3:0] xa, input logic [3:0] ya, input logic [3:0] ta,
                       input logic vb, input logic [3:0] xb, input logic [3:0] yb, input logic [3:0] tb);
    @(posedge clk);
    #1;
    rst              = r;
    bus.ReqValidAxSI = va;
    bus.ReqXAxDI     = mask4(xa);
    bus.ReqYAxDI     = mask4(ya);
    bus.ReqTagAxDI   = ta;
    bus.ReqValidBxSI = vb;
    bus.ReqXBxDI     = mask4(xb);
    bus.ReqYBxDI     = mask4(yb);
    bus.ReqTagBxDI   = tb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  int z_base;

  initial begin
    bus.ReqValidAxSI = 1'b0; bus.ReqXAxDI = '0; bus.ReqYAxDI = '0; bus.ReqTagAxDI = '0;
    bus.ReqValidBxSI = 1'b0; bus.ReqXBxDI = '0; bus.ReqYBxDI = '0; bus.ReqTagBxDI = '0;

    // Reset with A requesting: no grant until released
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 4'h9, 4'h6, 4'h3, 1'b0, 4'h0, 4'h0, 4'h0);
      check_eq("rst_ready_a", 32'(bus.ReqReadyAxSO), 32'h0);
    end
    check_eq("rst_busy", 32'(bus.BusyxSO), 32'h0);
    check_eq("rst_x", 32'(bus._XxDO), 32'h0);
    check_eq("rst_z", 32'(bus._ZxDO), 32'h0);

    drive(1'b0, 1'b1, 4'h9, 4'h6, 4'h3, 1'b0, 4'h0, 4'h0, 4'h0);
    check_eq("first_grant_a", 32'(bus.ReqReadyAxSO), 32'h1);
    idle(1);
    check_eq("issue_x", 32'(unmask(bus._XxDO)), 32'h9);
    check_eq("issue_y", 32'(unmask(bus._YxDO)), 32'h6);
    check_eq("issue_busy", 32'(bus.BusyxSO), 32'h1);
    idle(1);
    check_eq("idle_x", 32'(bus._XxDO), 32'h0);
    check_eq("idle_y", 32'(bus._YxDO), 32'h0);
    check_eq("early_resp_a", 32'(bus.RespValidAxSO), 32'h0);
    idle(1);
    check_eq("first_resp_a", 32'(bus.RespValidAxSO), 32'h1);
    check_eq("first_resp_q", 32'(unmask(bus.RespQxDO)), 32'h4);
    check_eq("first_resp_tag", 32'(bus.RespTagxDO), 32'h3);
    idle(1);
    check_eq("after_resp_busy", 32'(bus.BusyxSO), 32'h0);

    // Contended stream alternates starting with A
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 4'(i), 4'(15 - i), 4'h3, 1'b1, 4'(i ^ 5), 4'(i + 2), 4'hC);
      check_eq("alt_grant_a", 32'(bus.ReqReadyAxSO), 32'((i % 2) == 0));
      check_eq("alt_grant_b", 32'(bus.ReqReadyBxSO), 32'((i % 2) == 1));
    end
    idle(3);

    // Single-requester grants leave the pointer alone
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'(i + 1), 4'(i + 7), 4'hB);
      check_eq("b_only_grant", 32'(bus.ReqReadyBxSO), 32'h1);
    end
    drive(1'b0, 1'b1, 4'h2, 4'h3, 4'h1, 1'b1, 4'h4, 4'h5, 4'h2);
    check_eq("ptr_hold_a", 32'(bus.ReqReadyAxSO), 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'(i + 3), 4'(i + 10), 4'hA, 1'b0, 4'h0, 4'h0, 4'h0);
      check_eq("a_only_grant", 32'(bus.ReqReadyAxSO), 32'h1);
    end
    drive(1'b0, 1'b1, 4'h6, 4'h7, 4'h1, 1'b1, 4'h8, 4'h9, 4'h2);
    check_eq("ptr_hold_b", 32'(bus.ReqReadyBxSO), 32'h1);
    idle(3);

    // Exhaustive operand sweep through A, back to back
    z_base = z_changes;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        drive(1'b0, 1'b1, 4'(x), 4'(y), 4'(x ^ y), 1'b0, 4'h0, 4'h0, 4'h0);
        check_eq("sweep_grant", 32'(bus.ReqReadyAxSO), 32'h1);
      end
    end
    idle(3);
    check_eq("z_not_stuck", 32'((z_changes - z_base) >= 200), 32'h1);

    // Reset with two operations in flight discards them
    drive(1'b0, 1'b1, 4'h1, 4'h2, 4'h5, 1'b0, 4'h0, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 4'h3, 4'h4, 4'h6, 1'b0, 4'h0, 4'h0, 4'h0);
    drive(1'b1, 1'b1, 4'h3, 4'h4, 4'h6, 1'b0, 4'h0, 4'h0, 4'h0);
    check_eq("midrst_ready", 32'(bus.ReqReadyAxSO), 32'h0);
    idle(1);
    check_eq("post_rst_busy", 32'(bus.BusyxSO), 32'h0);
    check_eq("post_rst_resp", 32'({bus.RespValidAxSO, bus.RespValidBxSO}), 32'h0);
    idle(3);

    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h7, 4'h8, 4'h9);
    check_eq("post_rst_grant_b", 32'(bus.ReqReadyBxSO), 32'h1);
    idle(3);
    check_eq("post_rst_resp_b", 32'(bus.RespValidBxSO), 32'h1);
    check_eq("post_rst_tag", 32'(bus.RespTagxDO), 32'h9);
    check_eq("post_rst_q", 32'(unmask(bus.RespQxDO)), 32'(gf_ref(4'h7, 4'h8)));
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
